// File: rtl/reg_ctx_pkg.sv
// Shared types and constants for the register context save/restore engine.
package reg_ctx_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    localparam logic MODE_SAVE    = 1'b0;
    localparam logic MODE_RESTORE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        RD_REQ,
        RF_WR,
        DONE
    } ctxState_t;

endpackage

// File: rtl/reg_ctx_checksum.sv
// XOR accumulator over transferred words; Clear restarts it, Enable folds Data in.
module reg_ctx_checksum #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Clear,
    input  logic              Enable,
    input  logic [DATA_W-1:0] Data,
    output logic [DATA_W-1:0] Sum
);

    always_ff @(posedge CLK) begin
        if (RST || Clear) begin
            Sum <= '0;
        end else if (Enable) begin
            Sum <= Sum ^ Data;
        end
    end

endmodule

// File: rtl/reg_ctx_engine.sv
// Context save/restore engine: copies r[FIRST_REG..LAST_REG] between register file and memory.
// Define REG_CTX_CHECKSUM_EN to build the XOR checksum of transferred words; otherwise Checksum is 0.
module reg_ctx_engine
    import reg_ctx_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Start,
    input  logic                 Mode,
    input  logic [ADDR_W-1:0]    BaseAddr,
    output logic                 Busy,
    output logic                 Done,
    output logic [31:0]          Checksum,
    output logic [RF_ADDR_W-1:0] RfReadReg,
    input  logic [RF_DATA_W-1:0] RfReadData,
    output logic [RF_ADDR_W-1:0] RfWriteReg,
    output logic [RF_DATA_W-1:0] RfWriteData,
    output logic                 RfWE,
    output logic [ADDR_W-1:0]    MemAddr,
    output logic [31:0]          MemWData,
    output logic                 MemWE,
    output logic                 MemRE,
    input  logic [31:0]          MemRData,
    input  logic                 MemReady
);

    ctxState_t            state, stateNext;
    logic [RF_ADDR_W-1:0] idx, idxNext;
    logic [ADDR_W-1:0]    baseReg;
    logic [ADDR_W-1:0]    wordAddr;
    logic [RF_DATA_W-1:0] dataReg;
    logic                 startAccept;
    logic                 lastIdx;

    assign startAccept = (state == IDLE) && Start;
    assign lastIdx     = (idx == RF_ADDR_W'(LAST_REG));
    assign wordAddr    = baseReg + ADDR_W'({idx, 2'b00});

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            idx   <= RF_ADDR_W'(FIRST_REG);
        end else begin
            state <= stateNext;
            idx   <= idxNext;
        end
    end

    // Data registers need no reset: they only reach the outputs through state-gated decode.
    always_ff @(posedge CLK) begin
        if (startAccept) begin
            baseReg <= {BaseAddr[ADDR_W-1:2], 2'b00};
        end
        if ((state == RD_REQ) && MemReady) begin
            dataReg <= MemRData;
        end
    end

    always_comb begin
        stateNext   = state;
        idxNext     = idx;
        Busy        = (state != IDLE);
        Done        = 1'b0;
        RfReadReg   = '0;
        RfWriteReg  = '0;
        RfWriteData = '0;
        RfWE        = 1'b0;
        MemAddr     = '0;
        MemWData    = '0;
        MemWE       = 1'b0;
        MemRE       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    idxNext   = RF_ADDR_W'(FIRST_REG);
                    stateNext = (Mode == MODE_RESTORE) ? RD_REQ : SAVE;
                end
            end
            SAVE: begin
                RfReadReg = idx;
                MemWE     = 1'b1;
                MemAddr   = wordAddr;
                MemWData  = RfReadData;
                if (MemReady) begin
                    if (lastIdx) stateNext = DONE;
                    else         idxNext   = idx + 1'b1;
                end
            end
            RD_REQ: begin
                MemRE   = 1'b1;
                MemAddr = wordAddr;
                if (MemReady) stateNext = RF_WR;
            end
            RF_WR: begin
                RfWE        = (idx != '0);
                RfWriteReg  = idx;
                RfWriteData = dataReg;
                if (lastIdx) begin
                    stateNext = DONE;
                end else begin
                    idxNext   = idx + 1'b1;
                    stateNext = RD_REQ;
                end
            end
            DONE: begin
                Done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

`ifdef REG_CTX_CHECKSUM_EN
    logic                 csEnable;
    logic [RF_DATA_W-1:0] csData;

    assign csEnable = ((state == SAVE) && MemReady) || (state == RF_WR);
    assign csData   = (state == RF_WR) ? dataReg : RfReadData;

    reg_ctx_checksum #(
        .DATA_W (RF_DATA_W)
    ) uChecksum (
        .CLK    (CLK),
        .RST    (RST),
        .Clear  (startAccept),
        .Enable (csEnable),
        .Data   (csData),
        .Sum    (Checksum)
    );
`else
    assign Checksum = '0;
`endif

endmodule

// File: tb/tb_reg_ctx_engine.sv
// Directed bench for reg_ctx_engine with a register-file model and a latency-programmable memory.
module tb_reg_ctx_engine;
    import reg_ctx_pkg::*;

    logic        CLK = 1'b0;
    logic        RST, Start, Mode;
    logic [31:0] BaseAddr;
    logic        Busy, Done;
    logic [31:0] Checksum;
    logic [4:0]  RfReadReg, RfWriteReg;
    logic [31:0] RfReadData, RfWriteData;
    logic        RfWE;
    logic [31:0] MemAddr, MemWData, MemRData;
    logic        MemWE, MemRE, MemReady;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rf [32];
    logic        rfLoadReq;
    logic [31:0] rfLoadBase;
    int          memDelay;
    int          waitCnt = 0;
    logic [31:0] rdTag, rdBase;

    int          rfWeCycles = 0, rfWePulses = 0, rfWeZero = 0, bothHigh = 0, memReCycles = 0;
    logic        rfWePrev = 1'b0;
    logic [31:0] wrAddrQ[$];
    logic [31:0] wrDataQ[$];

    reg_ctx_engine #(.ADDR_W(32), .FIRST_REG(1), .LAST_REG(31)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Mode(Mode), .BaseAddr(BaseAddr),
        .Busy(Busy), .Done(Done), .Checksum(Checksum),
        .RfReadReg(RfReadReg), .RfReadData(RfReadData),
        .RfWriteReg(RfWriteReg), .RfWriteData(RfWriteData), .RfWE(RfWE),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE), .MemRE(MemRE),
        .MemRData(MemRData), .MemReady(MemReady)
    );

    always #5 CLK = ~CLK;

    assign RfReadData = rf[RfReadReg];
    assign MemReady   = (MemWE || MemRE) && (waitCnt >= memDelay);
    assign MemRData   = rdTag | ((MemAddr - rdBase) >> 2);

    // Register file model; writes r0 too so a stray write to it is observable.
    always @(posedge CLK) begin
        if (rfLoadReq) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : rfLoadBase + 32'(i);
        end else if (RfWE) begin
            rf[RfWriteReg] <= RfWriteData;
        end
        if ((MemWE || MemRE) && !MemReady) waitCnt <= waitCnt + 1;
        else                               waitCnt <= 0;
    end

    always @(negedge CLK) begin
        if (MemWE && MemReady) begin
            wrAddrQ.push_back(MemAddr);
            wrDataQ.push_back(MemWData);
        end
        if (RfWE) begin
            rfWeCycles <= rfWeCycles + 1;
            if (!rfWePrev) rfWePulses <= rfWePulses + 1;
            if (RfWriteReg == 5'd0) rfWeZero <= rfWeZero + 1;
        end
        if (MemWE && MemRE) bothHigh <= bothHigh + 1;
        if (MemRE) memReCycles <= memReCycles + 1;
        rfWePrev <= RfWE;
    end

    task automatic loadRf(input logic [31:0] b);
        @(posedge CLK); #1;
        rfLoadBase = b;
        rfLoadReq  = 1'b1;
        @(posedge CLK); #1;
        rfLoadReq  = 1'b0;
    endtask

    task automatic startOp(input logic m, input logic [31:0] b);
        @(posedge CLK); #1;
        Start = 1'b1; Mode = m; BaseAddr = b;
        @(posedge CLK); #1;
        Start = 1'b0; Mode = 1'b0; BaseAddr = 32'h0;
    endtask

    task automatic waitDone(input int from, output int cyc);
        cyc = from;
        @(negedge CLK);
        while (!Done && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic test_reset;
        RST = 1'b1; Start = 1'b0; Mode = 1'b0; BaseAddr = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        vectors++;
        if ({Busy, Done, RfWE, MemWE, MemRE} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 00000", {Busy, Done, RfWE, MemWE, MemRE});
        end
        vectors++;
        if ({MemAddr, MemWData, RfReadReg, RfWriteReg, RfWriteData} !== 106'b0) begin
            miscompares++;
            $display("FAIL reset_buses got addr=%h wd=%h rr=%h wr=%h rwd=%h want all 0",
                     MemAddr, MemWData, RfReadReg, RfWriteReg, RfWriteData);
        end
        vectors++;
        if (Checksum !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_checksum got %h want 0", Checksum);
        end
        RST = 1'b0;
    endtask

    task automatic test_save;
        int cyc, q0, err;
        logic [31:0] expCs;
        loadRf(32'h100);
        memDelay = 0;
        q0 = wrAddrQ.size();
        startOp(MODE_SAVE, 32'h1000);
        vectors++;
        if (Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL save_busy_rise got %b want 1", Busy);
        end
        waitDone(1, cyc);
        vectors++;
        if (cyc != 32) begin
            miscompares++;
            $display("FAIL save_latency got %0d want 32", cyc);
        end
        vectors++;
        if (Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL save_busy_done got %b want 1", Busy);
        end
        vectors++;
        if (wrAddrQ.size() - q0 != 31) begin
            miscompares++;
            $display("FAIL save_wr_count got %0d want 31", wrAddrQ.size() - q0);
        end else begin
            err = 0;
            for (int i = 0; i < 31; i++) begin
                if (wrAddrQ[q0+i] !== 32'h1004 + 32'(4*i) || wrDataQ[q0+i] !== 32'h101 + 32'(i)) begin
                    err++;
                    if (err == 1)
                        $display("FAIL save_word[%0d] got %h/%h want %h/%h", i, wrAddrQ[q0+i],
                                 wrDataQ[q0+i], 32'h1004 + 32'(4*i), 32'h101 + 32'(i));
                end
            end
            vectors++;
            if (err != 0) miscompares++;
        end
`ifdef REG_CTX_CHECKSUM_EN
        expCs = 32'h100;
`else
        expCs = 32'h0;
`endif
        vectors++;
        if (Checksum !== expCs) begin
            miscompares++;
            $display("FAIL save_checksum got %h want %h", Checksum, expCs);
        end
        repeat (3) @(posedge CLK);
        #1;
        vectors++;
        if ({Busy, Done} !== 2'b00 || Checksum !== expCs) begin
            miscompares++;
            $display("FAIL save_idle got busy/done=%b cs=%h want 00/%h", {Busy, Done}, Checksum, expCs);
        end
    endtask

    task automatic test_restore;
        int cyc, p0, c0, z0, r0, q0, err;
        logic [31:0] expCs;
        loadRf(32'hDEAD0000);
        memDelay = 2; rdTag = 32'hA000_0000; rdBase = 32'h2000;
        p0 = rfWePulses; c0 = rfWeCycles; z0 = rfWeZero; r0 = bothHigh; q0 = wrAddrQ.size();
        startOp(MODE_RESTORE, 32'h2000);
        waitDone(1, cyc);
        vectors++;
        if (cyc != 125) begin
            miscompares++;
            $display("FAIL restore_latency got %0d want 125", cyc);
        end
        @(posedge CLK); #1;
        err = 0;
        for (int i = 1; i < 32; i++) begin
            if (rf[i] !== (32'hA000_0000 | 32'(i))) begin
                err++;
                if (err == 1) $display("FAIL restore_r%0d got %h want %h", i, rf[i], 32'hA000_0000 | 32'(i));
            end
        end
        vectors++;
        if (err != 0) miscompares++;
        vectors++;
        if (rf[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL restore_r0 got %h want 0", rf[0]);
        end
        vectors++;
        if (rfWePulses - p0 != 31 || rfWeCycles - c0 != 31) begin
            miscompares++;
            $display("FAIL restore_we_pulses got %0d pulses/%0d cycles want 31/31", rfWePulses - p0, rfWeCycles - c0);
        end
        vectors++;
        if (rfWeZero != z0 || bothHigh != r0 || wrAddrQ.size() != q0) begin
            miscompares++;
            $display("FAIL restore_illegal got r0wr=%0d both=%0d memwr=%0d want 0/0/0",
                     rfWeZero - z0, bothHigh - r0, wrAddrQ.size() - q0);
        end
`ifdef REG_CTX_CHECKSUM_EN
        expCs = 32'hA000_0000;
`else
        expCs = 32'h0;
`endif
        vectors++;
        if (Checksum !== expCs) begin
            miscompares++;
            $display("FAIL restore_checksum got %h want %h", Checksum, expCs);
        end
    endtask

    task automatic test_wrap;
        int cyc, q0, err;
        logic [31:0] expA;
        loadRf(32'h300);
        memDelay = 0;
        q0 = wrAddrQ.size();
        startOp(MODE_SAVE, 32'hFFFF_FFF3);
        waitDone(1, cyc);
        vectors++;
        if (wrAddrQ.size() - q0 != 31) begin
            miscompares++;
            $display("FAIL wrap_count got %0d want 31", wrAddrQ.size() - q0);
        end else begin
            vectors++;
            if (wrAddrQ[q0] !== 32'hFFFF_FFF4 || wrAddrQ[q0+2] !== 32'hFFFF_FFFC ||
                wrAddrQ[q0+3] !== 32'h0 || wrAddrQ[q0+30] !== 32'h6C) begin
                miscompares++;
                $display("FAIL wrap_corners got %h %h %h %h want fffffff4 fffffffc 0 6c",
                         wrAddrQ[q0], wrAddrQ[q0+2], wrAddrQ[q0+3], wrAddrQ[q0+30]);
            end
            err = 0;
            for (int i = 0; i < 31; i++) begin
                expA = 32'hFFFF_FFF0 + 32'(4*(i+1));
                if (wrAddrQ[q0+i] !== expA) begin
                    err++;
                    if (err == 1) $display("FAIL wrap_addr[%0d] got %h want %h", i, wrAddrQ[q0+i], expA);
                end
            end
            vectors++;
            if (err != 0) miscompares++;
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_start_ignored;
        int cyc, q0, m0, err;
        loadRf(32'h100);
        memDelay = 1;
        q0 = wrAddrQ.size(); m0 = memReCycles;
        startOp(MODE_SAVE, 32'h1000);
        repeat (4) @(posedge CLK);
        #1;
        Start = 1'b1; Mode = MODE_RESTORE; BaseAddr = 32'h5000;
        @(posedge CLK); #1;
        Start = 1'b0; Mode = 1'b0; BaseAddr = 32'h0;
        waitDone(6, cyc);
        vectors++;
        if (cyc != 63) begin
            miscompares++;
            $display("FAIL ignore_latency got %0d want 63", cyc);
        end
        err = (wrAddrQ.size() - q0 != 31) ? 1 : 0;
        for (int i = 0; i < 31 && err == 0; i++)
            if (wrAddrQ[q0+i] !== 32'h1004 + 32'(4*i)) err++;
        vectors++;
        if (err != 0 || memReCycles != m0) begin
            miscompares++;
            $display("FAIL ignore_transfer got count=%0d re=%0d want 31/0", wrAddrQ.size() - q0, memReCycles - m0);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_rst_mid;
        int n, c0, err;
        loadRf(32'h5500);
        memDelay = 0; rdTag = 32'hB000_0000; rdBase = 32'h3000;
        startOp(MODE_RESTORE, 32'h3000);
        n = 0;
        @(negedge CLK);
        while (!(MemRE && MemAddr == 32'h3028) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        vectors++;
        if (n >= 500) begin
            miscompares++;
            $display("FAIL rst_reach_idx10 got timeout want MemRE at 00003028");
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        c0 = rfWeCycles;
        vectors++;
        if ({Busy, MemWE, MemRE, RfWE} !== 4'b0 || Checksum !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_idle got busy/we/re/rfwe=%b cs=%h want 0000/0", {Busy, MemWE, MemRE, RfWE}, Checksum);
        end
        repeat (10) @(posedge CLK);
        #1;
        vectors++;
        if (rfWeCycles != c0) begin
            miscompares++;
            $display("FAIL rst_no_rfwe got %0d writes want 0", rfWeCycles - c0);
        end
        err = 0;
        for (int i = 1; i < 32; i++) begin
            if (rf[i] !== ((i < 10) ? (32'hB000_0000 | 32'(i)) : (32'h5500 + 32'(i)))) begin
                err++;
                if (err == 1) $display("FAIL rst_r%0d got %h", i, rf[i]);
            end
        end
        vectors++;
        if (err != 0) miscompares++;
    endtask

    task automatic test_back_to_back;
        int cyc;
        loadRf(32'h100);
        memDelay = 0; rdTag = 32'hA000_0000; rdBase = 32'h2000;
        startOp(MODE_SAVE, 32'h1000);
        waitDone(1, cyc);
        @(posedge CLK); #1;
        vectors++;
        if (Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_busy_fall got %b want 0", Busy);
        end
        Start = 1'b1; Mode = MODE_RESTORE; BaseAddr = 32'h2000;
        @(posedge CLK); #1;
        Start = 1'b0; Mode = 1'b0; BaseAddr = 32'h0;
        vectors++;
        if ({Busy, MemRE, MemAddr} !== {2'b11, 32'h2004}) begin
            miscompares++;
            $display("FAIL b2b_accept got busy/re=%b addr=%h want 11/00002004", {Busy, MemRE}, MemAddr);
        end
        waitDone(1, cyc);
        vectors++;
        if (cyc != 63) begin
            miscompares++;
            $display("FAIL b2b_latency got %0d want 63", cyc);
        end
        @(posedge CLK); #1;
        vectors++;
        if (rf[31] !== 32'hA000_001F) begin
            miscompares++;
            $display("FAIL b2b_r31 got %h want a000001f", rf[31]);
        end
    endtask

    task automatic test_checksum;
        int cyc;
        loadRf(32'h0);
        memDelay = 0;
        startOp(MODE_SAVE, 32'h0);
        waitDone(1, cyc);
        vectors++;
        if (Checksum !== 32'h0) begin
            miscompares++;
            $display("FAIL checksum_xor_1_31 got %h want 0", Checksum);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        RST = 1'b1; Start = 1'b0; Mode = 1'b0; BaseAddr = 32'h0;
        rfLoadReq = 1'b0; rfLoadBase = 32'h0; memDelay = 0;
        rdTag = 32'h0; rdBase = 32'h0;
        test_reset();
        test_save();
        test_restore();
        test_wrap();
        test_start_ignored();
        test_rst_mid();
        test_back_to_back();
        test_checksum();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
